// File: rtl/lighting_pkg.sv
// Shared types and defaults for the lighting ramp controller and its stepper.
package lighting_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RAMP   = 2'd2
    } ramp_state_t;

    typedef logic [3:0] level_t;

    localparam level_t TCODE_MAX_DEFAULT = 4'd11;

endpackage

// File: rtl/level_stepper.sv
// One 4-bit level register that moves a single unit toward its target per enable.
module level_stepper (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] target,
    output logic [3:0] level
);

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 4'd0;
        end else if (en) begin
            if (level < target) begin
                level <= level + 4'd1;
            end else if (level > target) begin
                level <= level - 4'd1;
            end
        end
    end

endmodule

// File: rtl/lighting_ramp_controller.sv
// Owns the LightingSystem inputs and ramps lamp count / shade level toward its targets
// one unit per step after the inputs have been quiet for a settle window.
module lighting_ramp_controller
    import lighting_pkg::*;
#(
    parameter logic [3:0]  TCODE_MAX     = TCODE_MAX_DEFAULT,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned STEP_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        slot_tick,
    input  logic [3:0]  ulight_in,
    input  logic        ulight_vld,
    input  logic [3:0]  length_in,
    input  logic        length_vld,
    input  logic [3:0]  tgt_lightnum,
    input  logic [3:0]  tgt_wshade,
    output logic [3:0]  tcode,
    output logic [3:0]  ulight,
    output logic [3:0]  lenght,
    output logic [3:0]  lamp_cur,
    output logic [3:0]  shade_cur,
    output logic [15:0] lamp_state,
    output logic        busy,
    output logic        ramp_done
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned STP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    ramp_state_t      state, state_next;
    logic [SET_W-1:0] settle_cnt, settle_cnt_next;
    logic [STP_W-1:0] step_cnt, step_cnt_next;
    logic             change;
    logic             at_target;
    logic             step_en;
    logic             done_next;
    logic             busy_next;

    assign change    = slot_tick | ulight_vld | length_vld;
    assign at_target = (lamp_cur == tgt_lightnum) && (shade_cur == tgt_wshade);

    // Input holding registers feeding LightingSystem.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcode  <= 4'd0;
            ulight <= 4'd0;
            lenght <= 4'd0;
        end else begin
            if (slot_tick) begin
                tcode <= (tcode == TCODE_MAX) ? 4'd0 : tcode + 4'd1;
            end
            if (ulight_vld) begin
                ulight <= ulight_in;
            end
            if (length_vld) begin
                lenght <= length_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            step_cnt   <= '0;
            busy       <= 1'b0;
            ramp_done  <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
            step_cnt   <= step_cnt_next;
            busy       <= busy_next;
            ramp_done  <= done_next;
        end
    end

    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        step_cnt_next   = step_cnt;
        step_en         = 1'b0;
        done_next       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (change || !at_target) begin
                    state_next      = ST_SETTLE;
                    settle_cnt_next = '0;
                end
            end
            ST_SETTLE: begin
                if (change) begin
                    settle_cnt_next = '0;
                end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_next    = ST_RAMP;
                    step_cnt_next = '0;
                end else begin
                    settle_cnt_next = settle_cnt + SET_W'(1);
                end
            end
            ST_RAMP: begin
                // A change freezes the levels where they are and re-arms the settle window.
                if (change) begin
                    state_next      = ST_SETTLE;
                    settle_cnt_next = '0;
                end else if (at_target) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (step_cnt == STP_W'(STEP_CYCLES - 1)) begin
                    step_en       = 1'b1;
                    step_cnt_next = '0;
                end else begin
                    step_cnt_next = step_cnt + STP_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // busy stays high through the ramp_done cycle.
        busy_next = (state_next != ST_IDLE) || done_next;
    end

    level_stepper u_lamp_stepper (
        .clk    (clk),
        .rst    (rst),
        .en     (step_en),
        .target (tgt_lightnum),
        .level  (lamp_cur)
    );

    level_stepper u_shade_stepper (
        .clk    (clk),
        .rst    (rst),
        .en     (step_en),
        .target (tgt_wshade),
        .level  (shade_cur)
    );

    always_comb begin
        lamp_state = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            lamp_state[i] = (4'(i) < lamp_cur);
        end
    end

endmodule

// File: tb/tb_lighting_ramp_controller.sv
// Bench for lighting_ramp_controller: directed vector table, corner sequences, random run vs. a timeline model.
module tb_lighting_ramp_controller;

    localparam int S = 3;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slot_tick = 1'b0;
    logic [3:0]  ulight_in = 4'd0;
    logic        ulight_vld = 1'b0;
    logic [3:0]  length_in = 4'd0;
    logic        length_vld = 1'b0;
    logic [3:0]  tgt_lightnum = 4'd0;
    logic [3:0]  tgt_wshade = 4'd0;
    logic [3:0]  tcode, ulight, lenght, lamp_cur, shade_cur;
    logic [15:0] lamp_state;
    logic        busy, ramp_done;

    always #5 clk = ~clk;

    lighting_ramp_controller #(
        .SETTLE_CYCLES (S),
        .STEP_CYCLES   (P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .slot_tick    (slot_tick),
        .ulight_in    (ulight_in),
        .ulight_vld   (ulight_vld),
        .length_in    (length_in),
        .length_vld   (length_vld),
        .tgt_lightnum (tgt_lightnum),
        .tgt_wshade   (tgt_wshade),
        .tcode        (tcode),
        .ulight       (ulight),
        .lenght       (lenght),
        .lamp_cur     (lamp_cur),
        .shade_cur    (shade_cur),
        .lamp_state   (lamp_state),
        .busy         (busy),
        .ramp_done    (ramp_done)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Timeline model: an active ramp is described by the cycle its settle window began.
    logic [3:0] m_tcode = 0, m_ulight = 0, m_len = 0, m_lamp = 0, m_shade = 0;
    logic       m_active = 0, m_done = 0, m_busy = 0;
    int         m_anchor = 0;
    int         mcyc = 0;

    typedef struct {
        int          cyc;
        logic        ulv;
        logic [3:0]  ul;
        logic [3:0]  tl;
        logic [3:0]  tw;
        logic [3:0]  lamp;
        logic        busy;
        logic        done;
        logic [15:0] therm;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic chg, met;
        int   el;
        chg = slot_tick | ulight_vld | length_vld;
        met = (m_lamp == tgt_lightnum) && (m_shade == tgt_wshade);
        el  = mcyc - m_anchor;
        if (rst) begin
            m_tcode = 0; m_ulight = 0; m_len = 0; m_lamp = 0; m_shade = 0;
            m_active = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (chg || !met) begin
                    m_active = 1;
                    m_anchor = mcyc + 1;
                end
            end else if (chg) begin
                m_anchor = mcyc + 1;
            end else if (el >= S) begin
                if (met) begin
                    m_active = 0;
                    m_done   = 1;
                end else if ((el - S) % P == P - 1) begin
                    if (m_lamp < tgt_lightnum) m_lamp++;
                    else if (m_lamp > tgt_lightnum) m_lamp--;
                    if (m_shade < tgt_wshade) m_shade++;
                    else if (m_shade > tgt_wshade) m_shade--;
                end
            end
            if (slot_tick) m_tcode = (m_tcode == 4'd11) ? 4'd0 : m_tcode + 4'd1;
            if (ulight_vld) m_ulight = ulight_in;
            if (length_vld) m_len = length_in;
        end
        m_busy = m_active || m_done;
        mcyc++;
    endtask

    task automatic check_model();
        logic [15:0] th;
        th = 16'((32'd1 << m_lamp) - 32'd1);
        vectors++;
        if (tcode !== m_tcode || ulight !== m_ulight || lenght !== m_len || lamp_cur !== m_lamp ||
            shade_cur !== m_shade || lamp_state !== th || busy !== m_busy || ramp_done !== m_done) begin
            miscompares++;
            $display("FAIL model cyc=%0d got tc=%h ul=%h len=%h lamp=%h shade=%h therm=%h busy=%b done=%b want tc=%h ul=%h len=%h lamp=%h shade=%h therm=%h busy=%b done=%b",
                     cyc, tcode, ulight, lenght, lamp_cur, shade_cur, lamp_state, busy, ramp_done,
                     m_tcode, m_ulight, m_len, m_lamp, m_shade, th, m_busy, m_done);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_model();
        slot_tick  = 1'b0;
        ulight_vld = 1'b0;
        length_vld = 1'b0;
    endtask

    task automatic wait_lamp(input logic [3:0] v);
        int n;
        n = 0;
        while (m_lamp != v && n < 200) begin
            step();
            n++;
        end
        chk("wait_lamp", 16'(lamp_cur), 16'(v));
    endtask

    initial begin
        int dones;
        int n0;

        tbl.push_back('{10, 1'b1, 4'd5, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000});
        tbl.push_back('{11, 1'b0, 4'd5, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0000});
        tbl.push_back('{17, 1'b0, 4'd5, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0000});
        tbl.push_back('{18, 1'b0, 4'd5, 4'd3, 4'd0, 4'd1, 1'b1, 1'b0, 16'h0001});
        tbl.push_back('{21, 1'b0, 4'd5, 4'd3, 4'd0, 4'd1, 1'b1, 1'b0, 16'h0001});
        tbl.push_back('{22, 1'b0, 4'd5, 4'd3, 4'd0, 4'd2, 1'b1, 1'b0, 16'h0003});
        tbl.push_back('{25, 1'b0, 4'd5, 4'd3, 4'd0, 4'd2, 1'b1, 1'b0, 16'h0003});
        tbl.push_back('{26, 1'b0, 4'd5, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 16'h0007});
        tbl.push_back('{27, 1'b0, 4'd5, 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 16'h0007});
        tbl.push_back('{28, 1'b0, 4'd5, 4'd3, 4'd0, 4'd3, 1'b0, 1'b0, 16'h0007});

        // Reset held for 20 cycles with all strobes idle.
        rst = 1'b1;
        repeat (20) begin
            step();
            chk("rst_busy", 16'(busy), 16'h0);
            chk("rst_lamp", 16'(lamp_cur), 16'h0);
        end
        rst = 1'b0;
        cyc = 0;

        // Table-driven single ramp 0 -> 3 from a ulight strobe at cycle 10.
        while (cyc <= 28) begin
            foreach (tbl[k]) begin
                if (tbl[k].cyc == cyc) begin
                    chk("tbl_lamp", 16'(lamp_cur), 16'(tbl[k].lamp));
                    chk("tbl_busy", 16'(busy), 16'(tbl[k].busy));
                    chk("tbl_done", 16'(ramp_done), 16'(tbl[k].done));
                    chk("tbl_therm", lamp_state, tbl[k].therm);
                    ulight_vld   = tbl[k].ulv;
                    ulight_in    = tbl[k].ul;
                    tgt_lightnum = tbl[k].tl;
                    tgt_wshade   = tbl[k].tw;
                end
            end
            step();
        end
        chk("tbl_ulight", 16'(ulight), 16'h5);

        // Twelve slot ticks: tcode climbs to 11 then wraps.
        for (int i = 1; i <= 12; i++) begin
            slot_tick = 1'b1;
            step();
            if (i == 11) chk("tcode_max", 16'(tcode), 16'hb);
            if (i == 12) chk("tcode_wrap", 16'(tcode), 16'h0);
        end
        repeat (20) step();

        // Two strobes two cycles apart restart the settle window; one ramp_done only.
        dones = 0;
        tgt_lightnum = 4'd1;
        for (int r = 0; r <= 30; r++) begin
            if (r == 0 || r == 2) begin
                ulight_vld = 1'b1;
                ulight_in  = 4'(r);
            end
            step();
            if (ramp_done) dones++;
            if (r + 1 == 9)  chk("restart_hold", 16'(lamp_cur), 16'h3);
            if (r + 1 == 10) chk("restart_step", 16'(lamp_cur), 16'h2);
            if (r + 1 == 15) chk("restart_done", 16'(ramp_done), 16'h1);
        end
        chk("restart_done_cnt", 16'(dones), 16'h1);

        // Mid-ramp retarget 5 -> 2 caught at lamp 3.
        tgt_lightnum = 4'd5;
        length_vld   = 1'b1;
        length_in    = 4'd9;
        step();
        wait_lamp(4'd3);
        tgt_lightnum = 4'd2;
        ulight_vld   = 1'b1;
        dones = 0;
        for (int r = 1; r <= 10; r++) begin
            step();
            if (ramp_done) dones++;
            if (r == 1) chk("retgt_busy", 16'(busy), 16'h1);
            if (r == 7) chk("retgt_hold", 16'(lamp_cur), 16'h3);
            if (r == 8) chk("retgt_step", 16'(lamp_cur), 16'h2);
            if (r == 9) chk("retgt_done", 16'(ramp_done), 16'h1);
            if (r == 10) chk("retgt_idle", 16'(busy), 16'h0);
        end
        chk("retgt_done_cnt", 16'(dones), 16'h1);

        // Reset while lamp_cur is 4.
        tgt_lightnum = 4'd6;
        ulight_vld   = 1'b1;
        step();
        wait_lamp(4'd4);
        rst = 1'b1;
        tgt_lightnum = 4'd0;
        step();
        rst = 1'b0;
        chk("mrst_lamp", 16'(lamp_cur), 16'h0);
        chk("mrst_busy", 16'(busy), 16'h0);
        chk("mrst_done", 16'(ramp_done), 16'h0);
        dones = 0;
        repeat (12) begin
            step();
            if (ramp_done) dones++;
        end
        chk("mrst_no_done", 16'(dones), 16'h0);

        // Random run against the model, alternating busy and quiet strobe density.
        n0 = 0;
        for (int i = 0; i < 3000; i++) begin
            int div;
            div = ((i / 500) % 2 == 0) ? 12 : 90;
            rst          = ($urandom % 600 == 0);
            slot_tick    = ($urandom % div == 0);
            ulight_vld   = ($urandom % div == 0);
            ulight_in    = 4'($urandom);
            length_vld   = ($urandom % div == 0);
            length_in    = 4'($urandom);
            if ($urandom % 40 == 0) tgt_lightnum = 4'($urandom);
            if ($urandom % 40 == 0) tgt_wshade   = 4'($urandom);
            step();
            if (ramp_done) n0++;
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
